// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit holding the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product upper half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;   // multiplicand / divisor magnitude
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn_a, sgn_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic [2*WIDTH-1:0] prod;

  assign sgn_a   = ~op[0] & opa[WIDTH-1];
  assign sgn_b   = ~op[0] & opb[WIDTH-1];
  assign mul_sum = mq_q[0] ? ({1'b0, acc_q} + {1'b0, dvs_q}) : {1'b0, acc_q};
  assign shifted = {acc_q, mq_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  // Remainder always stays below the divisor, so the low WIDTH bits of the difference are exact.
  assign sub     = shifted[WIDTH-1:0] - dvs_q;
  assign prod    = neg_if_wide({acc_q, mq_q}, neg_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    dvs_d   = dvs_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          div_d   = op[1];
          neg_d   = sgn_a ^ sgn_b;
          rneg_d  = sgn_a;
          dz_d    = (opb == '0);
          acc_d   = '0;
          mq_d    = neg_if(opa, sgn_a);
          dvs_d   = neg_if(opb, sgn_b);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (div_q) begin
          acc_d = ge ? sub : shifted[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          // With a zero divisor every step succeeds, so the remainder ends up as |opa|
          // and the remainder sign fix restores opa exactly.
          lo_d = dz_q ? '1 : neg_if(mq_q, neg_q);
          hi_d = neg_if(acc_q, rneg_q);
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      dvs_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      dvs_q   <= dvs_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with per-cycle comparison,
// directed corner cases and randomized operations with bus noise while busy.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference result as {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: 33 cycles busy, result lands on the last of them.
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          {p_hi, p_lo} <= ref_result(op, opa, opb);
          m_rem <= 33;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_rem != 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    opa = a;
    opb = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int bcyc);
    bit seen;
    seen = 1'b0;
    bcyc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bcyc++;
        if (noise && busy) begin
          start = 1'($urandom_range(0, 1));
          hi_we = 1'($urandom_range(0, 1));
          lo_we = 1'($urandom_range(0, 1));
          op    = 2'($urandom);
          opa   = $urandom;
          opb   = $urandom;
          wdata = $urandom;
        end
        step();
      end
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 60 cycles");
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = 32'h7FFFFFFF;
      5: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int bc;
    int dc;
    logic [63:0] r;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    chk_en = 1'b1;

    r = ref_result(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); check("model_multu", r, 64'hFFFFFFFE_00000001);
    r = ref_result(2'd0, 32'hFFFFFFFD, 32'd7);        check("model_mult", r, 64'hFFFFFFFF_FFFFFFEB);
    r = ref_result(2'd2, 32'hFFFFFFF9, 32'd2);        check("model_div", r, 64'hFFFFFFFF_FFFFFFFD);
    r = ref_result(2'd2, 32'h80000000, 32'hFFFFFFFF); check("model_div_ovf", r, 64'h00000000_80000000);
    r = ref_result(2'd3, 32'd100, 32'd0);             check("model_divz", r, 64'h00000064_FFFFFFFF);

    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1'b0, bc);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    step();
    check("done_single_pulse", 64'(done), 64'd0);

    launch(2'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(1'b0, bc);
    check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    launch(2'd1, 32'hFFFFFFFD, 32'd7);
    wait_done(1'b0, bc);
    check("multu_same_ops", {hi, lo}, 64'h00000006_FFFFFFEB);

    launch(2'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0, bc);
    check("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0, bc);
    check("div_overflow", {hi, lo}, 64'h00000000_80000000);

    launch(2'd3, 32'd100, 32'd0);
    wait_done(1'b0, bc);
    check("divz_busy_cycles", 64'(bc), 64'd33);
    check("divu_by_zero", {hi, lo}, 64'h00000064_FFFFFFFF);
    launch(2'd3, 32'd100, 32'd7);
    wait_done(1'b0, bc);
    check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);

    // Start and MTHI while busy are both ignored.
    launch(2'd1, 32'h00010000, 32'h00010000);
    repeat (5) step();
    start = 1'b1; op = 2'd3; opa = 32'd9; opb = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
    step();
    start = 1'b0; hi_we = 1'b0;
    wait_done(1'b0, bc);
    check("busy_ignores_inputs", {hi, lo}, 64'h00000001_00000000);
    wdata = 32'hABCD; lo_we = 1'b1;
    step();
    lo_we = 1'b0;
    check("mtlo_idle", {hi, lo}, 64'h00000001_0000ABCD);

    wdata = 32'h5555; hi_we = 1'b1; lo_we = 1'b1;
    step();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, 64'h00005555_00005555);

    wdata = 32'h77; hi_we = 1'b1;
    launch(2'd1, 32'd3, 32'd4);
    hi_we = 1'b0;
    check("mt_with_start_e0", {hi, lo}, 64'h00000077_00005555);
    wait_done(1'b0, bc);
    check("mt_with_start_result", {hi, lo}, 64'h00000000_0000000C);

    // Asynchronous reset in the middle of a divide.
    launch(2'd3, 32'd1000, 32'd3);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    dc = 0;
    repeat (40) begin
      step();
      if (done) dc++;
    end
    check("abort_no_done", 64'(dc), 64'd0);
    launch(2'd3, 32'd100, 32'd7);
    wait_done(1'b0, bc);
    check("after_abort_divu", {hi, lo}, 64'h00000002_0000000E);

    for (int k = 0; k < 150; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom;
        step();
      end
      hi_we = 1'($urandom_range(0, 1));
      lo_we = 1'($urandom_range(0, 1));
      wdata = $urandom;
      launch(2'($urandom), pick(), pick());
      hi_we = 1'b0;
      lo_we = 1'b0;
      wait_done(1'b1, bc);
      check("rand_busy_cycles", 64'(bc), 64'd33);
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
